// File: rtl/arbiter_puf_evaluator_if.sv
// Response channel of the arbiter PUF evaluator. The evaluator drives it as
// master and the challenge/response collection logic consumes it as slave.
interface arbiter_puf_evaluator_if #(
    parameter int CNT_W = 8
);
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_bit;
    logic             resp_stable;
    logic [CNT_W-1:0] ones_count;

    // Evaluator side: produces the voted response and waits for ready
    modport master (
        output resp_valid,
        output resp_bit,
        output resp_stable,
        output ones_count,
        input  resp_ready
    );

    // Collector side: accepts the voted response
    modport slave (
        input  resp_valid,
        input  resp_bit,
        input  resp_stable,
        input  ones_count,
        output resp_ready
    );
endinterface

// File: rtl/arbiter_puf_evaluator.sv
// Arbiter PUF evaluator. Applies a challenge to the mux chain, repeatedly
// clears the arbiter latch, fires the launch edge, waits a settle time and
// samples the synchronised arbiter output. After NUM_EVAL evaluations the
// samples are majority-voted and returned over a valid/ready handshake.
//
// Per-evaluation sequence (SETTLE_CYC + 3 cycles):
//   CLEAR (1) -> LAUNCH (1) -> SETTLE (SETTLE_CYC) -> SAMPLE (1)
// launch stays high from LAUNCH through SAMPLE so the race result is held
// while it crosses the 2-flop synchroniser.
module arbiter_puf_evaluator #(
    parameter int CHAL_W     = 32,
    parameter int SETTLE_CYC = 8,
    parameter int NUM_EVAL   = 7,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    output logic              busy,
    output logic [CHAL_W-1:0] chal_out,
    output logic              launch,
    output logic              arb_clear,
    input  logic              arb_out,
    arbiter_puf_evaluator_if.master resp
);

    // State encoding kept as plain constants for compatibility with older tools
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_SAMPLE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [CNT_W-1:0] NUM_EVAL_C    = CNT_W'(NUM_EVAL);
    localparam logic [CNT_W-1:0] HALF_EVAL_C   = CNT_W'(NUM_EVAL / 2);
    localparam logic [CNT_W-1:0] SETTLE_LAST_C = CNT_W'(SETTLE_CYC - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;

    logic [CNT_W-1:0] eval_cnt;
    logic [CNT_W-1:0] ones;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] eval_nxt;
    logic [CNT_W-1:0] ones_nxt;

    logic             arb_meta;
    logic             arb_s;

    logic             capture;
    logic             last_eval;

    logic             resp_valid_r;
    logic             resp_bit_r;
    logic             resp_stable_r;
    logic [CNT_W-1:0] ones_count_r;

    // Majority decision: NUM_EVAL is odd, so strictly more than half wins
    function automatic logic majority(input logic [CNT_W-1:0] n_ones);
        return (n_ones > HALF_EVAL_C);
    endfunction

    // A response is stable when every sample agreed
    function automatic logic unanimous(input logic [CNT_W-1:0] n_ones);
        return (n_ones == '0) || (n_ones == NUM_EVAL_C);
    endfunction

    // Running counts as they will be after the current SAMPLE cycle
    assign eval_nxt = eval_cnt + CNT_W'(1);
    assign ones_nxt = ones + {{(CNT_W-1){1'b0}}, arb_s};

    assign last_eval = (eval_nxt == NUM_EVAL_C);

    // Next-state decode; start is only honoured in IDLE with no pending response
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !resp_valid_r) begin
                    state_nxt = S_CLEAR;
                    capture   = 1'b1;
                end
            end
            S_CLEAR:  state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST_C) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: state_nxt = last_eval ? S_DONE : S_CLEAR;
            S_DONE: begin
                if (resp.resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control outputs registered from the next state so the mux chain and
    // arbiter latch never see decode glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            launch       <= 1'b0;
            arb_clear    <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            busy         <= (state_nxt != S_IDLE);
            launch       <= (state_nxt == S_LAUNCH) || (state_nxt == S_SETTLE) ||
                            (state_nxt == S_SAMPLE);
            arb_clear    <= (state_nxt == S_CLEAR);
            resp_valid_r <= (state_nxt == S_DONE);
        end
    end

    // Two-flop synchroniser for the asynchronous arbiter latch output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_meta <= 1'b0;
            arb_s    <= 1'b0;
        end else begin
            arb_meta <= arb_out;
            arb_s    <= arb_meta;
        end
    end

    // Challenge register: held on the mux selects until the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal_out <= '0;
        end else if (capture) begin
            chal_out <= challenge;
        end
    end

    // Evaluation and ones counters: cleared on capture, advanced in SAMPLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt <= '0;
            ones     <= '0;
        end else if (capture) begin
            eval_cnt <= '0;
            ones     <= '0;
        end else if (state == S_SAMPLE) begin
            eval_cnt <= eval_nxt;
            ones     <= ones_nxt;
        end
    end

    // Settle counter: restarted in LAUNCH, counts every SETTLE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == S_LAUNCH) begin
            settle_cnt <= '0;
        end else if (state == S_SETTLE) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    // Response registers: loaded on entry to DONE and held until the next run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_bit_r    <= 1'b0;
            resp_stable_r <= 1'b0;
            ones_count_r  <= '0;
        end else if ((state == S_SAMPLE) && last_eval) begin
            resp_bit_r    <= majority(ones_nxt);
            resp_stable_r <= unanimous(ones_nxt);
            ones_count_r  <= ones_nxt;
        end
    end

    assign resp.resp_valid  = resp_valid_r;
    assign resp.resp_bit    = resp_bit_r;
    assign resp.resp_stable = resp_stable_r;
    assign resp.ones_count  = ones_count_r;

endmodule

// File: tb/tb_arbiter_puf_evaluator.sv
// Directed bench for arbiter_puf_evaluator: a default-parameter instance and a
// boundary instance (NUM_EVAL=1, SETTLE_CYC=3) share clock and reset.
module tb_arbiter_puf_evaluator;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [31:0] challenge;
    logic        busy;
    logic [31:0] chal_out;
    logic        launch;
    logic        arb_clear;
    logic        arb_out;

    logic        start_b;
    logic [31:0] challenge_b;
    logic        busy_b;
    logic [31:0] chal_out_b;
    logic        launch_b;
    logic        arb_clear_b;
    logic        arb_out_b;

    int vectors;
    int miscompares;

    arbiter_puf_evaluator_if #(.CNT_W(8)) rif ();
    arbiter_puf_evaluator_if #(.CNT_W(8)) rif_b ();

    arbiter_puf_evaluator #(
        .CHAL_W(32), .SETTLE_CYC(8), .NUM_EVAL(7), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .busy(busy), .chal_out(chal_out), .launch(launch),
        .arb_clear(arb_clear), .arb_out(arb_out), .resp(rif)
    );

    arbiter_puf_evaluator #(
        .CHAL_W(32), .SETTLE_CYC(3), .NUM_EVAL(1), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .challenge(challenge_b),
        .busy(busy_b), .chal_out(chal_out_b), .launch(launch_b),
        .arb_clear(arb_clear_b), .arb_out(arb_out_b), .resp(rif_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full run on the default instance; arb_out is changed in each CLEAR
    // cycle to the next bit of pat (pat[0] first). Returns when resp_valid rises.
    task automatic run_eval(input logic [31:0] ch, input logic [6:0] pat, input bit poke_busy,
                            output int lat, output int nclr, output int nlch, output logic acc,
                            output logic rb, output logic rs, output logic [7:0] oc);
        int k;
        k = 0; lat = -1; nclr = 0; nlch = 0; rb = 1'b0; rs = 1'b0; oc = 8'h00;
        challenge = ch;
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = busy;
        if (arb_clear) begin
            arb_out = pat[0];
            k = 1;
            nclr = 1;
        end
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (poke_busy) begin
                if (e == 20) begin
                    start = 1'b1;
                    challenge = 32'hDEAD_BEEF;
                end else begin
                    start = 1'b0;
                end
            end
            if (arb_clear) begin
                nclr++;
                if (k < 7) arb_out = pat[k];
                k++;
            end
            if (launch) nlch++;
            if (rif.resp_valid) begin
                lat = e;
                rb = rif.resp_bit;
                rs = rif.resp_stable;
                oc = rif.ones_count;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int   lat, nclr, nlch, latb;
        logic acc, rb, rs;
        logic [7:0] oc;
        logic [6:0] fin;

        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0; challenge = '0; arb_out = 1'b0;
        start_b = 1'b0; challenge_b = '0; arb_out_b = 1'b0;
        rif.resp_ready = 1'b0;
        rif_b.resp_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst busy", busy, 0);
        chk("rst launch", launch, 0);
        chk("rst arb_clear", arb_clear, 0);
        chk("rst resp_valid", rif.resp_valid, 0);
        chk("rst chal_out", chal_out, 0);
        chk("rst ones_count", rif.ones_count, 0);
        chk("rst resp_bit", rif.resp_bit, 0);
        chk("rst resp_stable", rif.resp_stable, 0);
        rst_n = 1'b1;
        tick();

        // Normal evaluation, arb_out constantly 1
        rif.resp_ready = 1'b1;
        arb_out = 1'b1;
        run_eval(32'hA5A5_0F0F, 7'b1111111, 1'b0, lat, nclr, nlch, acc, rb, rs, oc);
        chk("norm accepted", acc, 1);
        chk("norm chal_out", chal_out, 32'hA5A5_0F0F);
        chk("norm clear pulses", nclr, 7);
        chk("norm launch cycles", nlch, 70);
        chk("norm latency", lat, 77);
        chk("norm resp_bit", rb, 1);
        chk("norm resp_stable", rs, 1);
        chk("norm ones_count", oc, 7);
        tick();
        chk("norm valid dropped", rif.resp_valid, 0);
        chk("norm idle", busy, 0);

        // Mixed samples 1,0,1,0,1,0,0; start the very next cycle after handshake
        run_eval(32'h0000_0001, 7'b0010101, 1'b0, lat, nclr, nlch, acc, rb, rs, oc);
        chk("mix1 back-to-back accept", acc, 1);
        chk("mix1 latency", lat, 77);
        chk("mix1 resp_bit", rb, 0);
        chk("mix1 resp_stable", rs, 0);
        chk("mix1 ones_count", oc, 3);
        tick();

        // Mixed samples 1,1,0,1,0,0,1 with backpressure and start gating
        rif.resp_ready = 1'b0;
        run_eval(32'h1234_5678, 7'b1001011, 1'b1, lat, nclr, nlch, acc, rb, rs, oc);
        chk("mix2 latency", lat, 77);
        chk("mix2 resp_bit", rb, 1);
        chk("mix2 resp_stable", rs, 0);
        chk("mix2 ones_count", oc, 4);
        chk("busy start ignored", chal_out, 32'h1234_5678);
        for (int i = 0; i < 20; i++) begin
            start = (i == 5) || (i == 6);
            challenge = 32'hDEAD_BEEF;
            tick();
            chk("bp resp_valid", rif.resp_valid, 1);
            chk("bp resp_bit", rif.resp_bit, 1);
            chk("bp resp_stable", rif.resp_stable, 0);
            chk("bp ones_count", rif.ones_count, 4);
            chk("bp chal_out", chal_out, 32'h1234_5678);
        end
        start = 1'b0;
        rif.resp_ready = 1'b1;
        tick();
        chk("bp handshake valid", rif.resp_valid, 0);
        chk("bp handshake idle", busy, 0);
        challenge = 32'hCAFE_F00D;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("next start chal_out", chal_out, 32'hCAFE_F00D);
        chk("next start busy", busy, 1);

        // Reset during SETTLE of the 3rd evaluation
        for (int i = 0; i < 25; i++) tick();
        chk("pre-reset launch", launch, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst launch", launch, 0);
        chk("async rst busy", busy, 0);
        chk("async rst resp_valid", rif.resp_valid, 0);
        chk("async rst arb_clear", arb_clear, 0);
        tick(); tick();
        rst_n = 1'b1;
        chk("post-rst chal_out", chal_out, 0);
        tick();
        run_eval(32'h5555_AAAA, 7'b0000001, 1'b0, lat, nclr, nlch, acc, rb, rs, oc);
        chk("fresh latency", lat, 77);
        chk("fresh ones_count", oc, 1);
        chk("fresh resp_bit", rb, 0);
        chk("fresh resp_stable", rs, 0);
        tick();

        // Synchroniser: random-phase toggling inside SETTLE, final level set
        // well before SAMPLE. Final levels 0,0,1,1,0,1,1 -> four ones.
        fin = 7'b1101100;
        lat = -1;
        challenge = 32'h0F0F_F0F0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            int ph;
            int j;
            tick();
            if (rif.resp_valid) begin
                lat = e;
                break;
            end
            ph = e % 11;
            j = e / 11;
            if (j < 7) begin
                if (ph >= 2 && ph <= 5) begin
                    #($urandom_range(0, 7));
                    arb_out = 1'($urandom_range(0, 1));
                end else if (ph == 6) begin
                    arb_out = fin[j];
                end
            end
        end
        chk("sync latency", lat, 77);
        chk("sync ones_count", rif.ones_count, 4);
        chk("sync resp_bit", rif.resp_bit, 1);
        chk("sync resp_stable", rif.resp_stable, 0);
        tick();

        // Boundary instance: NUM_EVAL=1, SETTLE_CYC=3, arb_out=0
        latb = -1;
        arb_out_b = 1'b0;
        rif_b.resp_ready = 1'b1;
        challenge_b = 32'h8000_0001;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("bnd chal_out", chal_out_b, 32'h8000_0001);
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (rif_b.resp_valid) begin
                latb = e;
                break;
            end
        end
        chk("bnd latency", latb, 6);
        chk("bnd resp_bit", rif_b.resp_bit, 0);
        chk("bnd resp_stable", rif_b.resp_stable, 1);
        chk("bnd ones_count", rif_b.ones_count, 0);
        tick();
        chk("bnd valid dropped", rif_b.resp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbiter_puf_evaluator.md
Name: arbiter_puf_evaluator

Overview:
- Drives the launch side of the arbiter PUF mux chain and reads back its response.
- Applies a challenge, fires a launch edge into both racing paths, and waits a settle time. It then samples the arbiter latch output, clears the latch and repeats.
- After NUM_EVAL evaluations it majority-votes one response bit and returns it over a valid/ready handshake to the challenge/response collection logic.

Parameters:
- CHAL_W, 32: challenge width; one select bit per mux stage.
- SETTLE_CYC, 8: cycles the launch edge is held before sampling; must be >= 3 to cover the internal 2-flop synchroniser. Legal range 3..255.
- NUM_EVAL, 7: evaluations per challenge. Must be odd, 1..255.
- CNT_W, 8: width of the evaluation, ones and settle counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request an evaluation of challenge
- challenge  in  CHAL_W  challenge, captured when start is accepted
- busy  out  1  evaluation in progress (state != IDLE)
- chal_out  out  CHAL_W  registered challenge driving the mux select lines
- launch  out  1  race launch edge into the mux chain
- arb_clear  out  1  resets the arbiter latch
- arb_out  in  1  arbiter latch output; asynchronous to clk
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_bit  out  1  majority-voted response
- resp_stable  out  1  all NUM_EVAL samples agreed
- ones_count  out  CNT_W  number of samples equal to 1

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0, including chal_out. All counters 0.
- arb_out passes through a 2-flop synchroniser, arb_s. Only arb_s is sampled.
- launch, arb_clear and busy are registered or decoded from the state register only; they must be glitch-free.
- launch=1 in LAUNCH, SETTLE and SAMPLE; 0 elsewhere. arb_clear=1 only in CLEAR.
- IDLE:
  - start=1 and resp_valid=0 -> capture challenge into chal_out; eval_cnt=0, ones=0; go to CLEAR.
  - start is ignored while busy=1 or resp_valid=1.
- CLEAR: 1 cycle -> LAUNCH.
- LAUNCH: 1 cycle; settle_cnt=0 -> SETTLE.
- SETTLE: settle_cnt increments each cycle; when settle_cnt==SETTLE_CYC-1 -> SAMPLE.
- SAMPLE:
  - ones += arb_s; eval_cnt += 1.
  - If the new eval_cnt==NUM_EVAL -> DONE, else -> CLEAR.
- Per-evaluation cost: SETTLE_CYC+3 cycles.
- DONE:
  - On entry, register resp_bit = (ones > NUM_EVAL/2).
  - resp_stable = (ones==0 or ones==NUM_EVAL).
  - ones_count = ones; resp_valid=1.
  - Hold all response outputs stable while resp_valid=1 and resp_ready=0.
  - resp_valid&resp_ready -> resp_valid=0 next cycle; go to IDLE.
- chal_out is held constant from capture until the next accepted start; it does not change in DONE/IDLE.
- Latency: start accepted at edge 0 -> resp_valid high after edge NUM_EVAL*(SETTLE_CYC+3). Defaults: 77.
- Throughput: handshake at edge N -> earliest next start accepted at edge N+1.
- resp_ready while resp_valid=0 has no effect.
- Reset mid-operation: immediately returns to IDLE; launch, arb_clear and resp_valid drop asynchronously; partial counts are discarded.
- Counters never wrap with legal parameters.

Test Plan:
- Normal evaluation (defaults): arb_out held 1; start with challenge=32'hA5A5_0F0F, resp_ready=1.
  - chal_out=A5A50F0F after edge 1.
  - 7 arb_clear pulses, each followed by launch high for 10 cycles.
  - resp_valid at edge 77 with resp_bit=1, resp_stable=1, ones_count=7.
- Mixed samples: arb_out driven 1,0,1,0,1,0,0 (changed during CLEAR) -> resp_bit=0, resp_stable=0, ones_count=3. Pattern 1,1,0,1,0,0,1 -> resp_bit=1, ones_count=4.
- Backpressure and start gating: resp_ready=0 for 20 cycles after resp_valid.
  - Outputs held, resp_valid held.
  - start pulsed during busy and during resp_valid is ignored (chal_out unchanged).
  - resp_ready=1 -> resp_valid low next cycle; new start accepted the cycle after.
- Reset mid-run: assert rst_n=0 during SETTLE of the 3rd evaluation.
  - launch=0, busy=0, resp_valid=0 immediately.
  - After release, a fresh start produces a full 77-cycle run with ones_count counted from 0.
- Boundary parameters: NUM_EVAL=1, SETTLE_CYC=3, arb_out=0.
  - resp_valid at edge 6; resp_bit=0, resp_stable=1, ones_count=0.
- Synchroniser: arb_out toggled asynchronously (random phase) within SETTLE, stable >= 2 cycles before SAMPLE -> sampled value equals the final arb_out level.
